vga_timing: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces the pixel counters `hCount`/`vCount`, the `bright` visible-area flag and active-low sync pulses. Sits directly upstream of the glyph/bit generator, which consumes `bright`, `hCount` and `vCount` to fetch glyph memory and drive `VGA_R/G/B`. Also drives the connector's `VGA_HS`/`VGA_VS` and a pixel-rate enable for downstream logic.

---
 rtl/vga_timing.sv | 92 +++++++++
 tb/tb_vga_timing.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator (hCount/vCount, bright, active-low
// syncs, pixel enable and frame-start pulse) driven from the system clock.
module vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [15:0] hCount,
  output logic [15:0] vCount,
  output logic        bright,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_BEG   = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [3:0]  div_cnt;
  logic        tick;
  logic        h_wrap, v_wrap;
  logic [15:0] h_nxt, v_nxt;
  logic        br_nxt, hs_nxt, vs_nxt;

  // Next raster position and its flag decode; flags are registered from this
  // so they change on the very edge the counters do.
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_nxt  = h_wrap ? 16'd0 : hCount + 16'd1;
    v_nxt  = vCount;
    if (h_wrap)
      v_nxt = v_wrap ? 16'd0 : vCount + 16'd1;
    br_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hs_nxt = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vs_nxt = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
  end

  // Clock divider: pix_en rises on the edge after div_cnt reaches its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
      pix_en  <= tick;
    end
  end

  // Raster counters and flags advance together once per pixel; frame_start
  // marks only a true wrap, never the reset-loaded origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount      <= '0;
      vCount      <= '0;
      bright      <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hCount <= h_nxt;
        vCount <= v_nxt;
        bright <= br_nxt;
        hsync  <= hs_nxt;
        vsync  <= vs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing. Three instances: default
// 640x480 timing, a tiny raster at CLK_DIV=1, and the same tiny raster at
// CLK_DIV=3. Expected values come from a closed-form position model.
module tb_vga_timing;

  typedef struct packed {
    logic        pe;
    logic [15:0] h;
    logic [15:0] v;
    logic        br;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [2:0] rstn = 3'b111;

  logic        pe0, br0, hs0, vs0, fs0;
  logic [15:0] h0, v0;
  logic        pe1, br1, hs1, vs1, fs1;
  logic [15:0] h1, v1;
  logic        pe2, br2, hs2, vs2, fs2;
  logic [15:0] h2, v2;

  exp_t o0, o1, o2;
  assign o0 = {pe0, h0, v0, br0, hs0, vs0, fs0};
  assign o1 = {pe1, h1, v1, br1, hs1, vs1, fs1};
  assign o2 = {pe2, h2, v2, br2, hs2, vs2, fs2};

  vga_timing dut0 (
    .clk(clk), .rst_n(rstn[0]), .pix_en(pe0), .hCount(h0), .vCount(v0),
    .bright(br0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut1 (
    .clk(clk), .rst_n(rstn[1]), .pix_en(pe1), .hCount(h1), .vCount(v1),
    .bright(br1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  vga_timing #(
    .CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut2 (
    .clk(clk), .rst_n(rstn[2]), .pix_en(pe2), .hCount(h2), .vCount(v2),
    .bright(br2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Expected outputs after the k-th clock edge following reset release
  // (k=0 is the reset state) for configuration cfg.
  function automatic exp_t model(int cfg, int k);
    int d, hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, n, p, hh, vv2;
    exp_t e;
    if (cfg == 0) begin
      d = 2; hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33;
    end else begin
      d = (cfg == 1) ? 1 : 3;
      hv = 8; hf = 2; hsw = 2; hb = 2; vv = 4; vf = 1; vsw = 1; vb = 1;
    end
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    n   = k / d;
    p   = n % (ht * vt);
    hh  = p % ht;
    vv2 = p / ht;
    e.pe = (k > 0) && (k % d == 0);
    e.h  = 16'(hh);
    e.v  = 16'(vv2);
    e.br = (hh < hv) && (vv2 < vv);
    e.hs = !((hh >= hv + hf) && (hh < hv + hf + hsw));
    e.vs = !((vv2 >= vv + vf) && (vv2 < vv + vf + vsw));
    e.fs = e.pe && (p == 0) && (n > 0);
    return e;
  endfunction

  // Reset instance w for a few cycles; returns just after release on a falling
  // edge so the next rising edge is edge k=1.
  task automatic pulse_reset(int w);
    @(negedge clk);
    rstn[w] = 1'b0;
    repeat (3) @(negedge clk);
    rstn[w] = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    rstn = 3'b000;
    repeat (2) @(negedge clk);
    e = model(0, 0);
    n_tests++;
    if (o0 !== e) begin n_fail++; $display("FAIL reset_d0 got=%h exp=%h", o0, e); end
    e = model(1, 0);
    n_tests++;
    if (o1 !== e) begin n_fail++; $display("FAIL reset_d1 got=%h exp=%h", o1, e); end
    e = model(2, 0);
    n_tests++;
    if (o2 !== e) begin n_fail++; $display("FAIL reset_d2 got=%h exp=%h", o2, e); end
    rstn = 3'b111;
    @(negedge clk);
    n_tests++;
    if (pe0 !== 1'b0 || h0 !== 16'd0) begin
      n_fail++; $display("FAIL first_edge got pe=%b h=%0d exp pe=0 h=0", pe0, h0);
    end
    @(negedge clk);
    n_tests++;
    if (pe0 !== 1'b1 || h0 !== 16'd1) begin
      n_fail++; $display("FAIL first_tick got pe=%b h=%0d exp pe=1 h=1", pe0, h0);
    end
  endtask

  task automatic test_cadence();
    exp_t e;
    int   npe = 0;
    pulse_reset(0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      sb.push_back(model(0, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o0 !== e) begin n_fail++; $display("FAIL cadence k=%0d got=%h exp=%h", k, o0, e); end
      if (pe0) npe++;
    end
    n_tests++;
    if (npe != 10) begin n_fail++; $display("FAIL cadence_count got=%0d exp=10", npe); end
  endtask

  task automatic test_hline();
    exp_t e, prev;
    bit   hs_fell = 0, hs_rose = 0, br_fell = 0, wrapped = 0;
    pulse_reset(0);
    prev = o0;
    for (int k = 1; k <= 1602; k++) begin
      @(posedge clk);
      sb.push_back(model(0, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o0 !== e) begin n_fail++; $display("FAIL hline k=%0d got=%h exp=%h", k, o0, e); end
      if (prev.hs && !o0.hs) begin
        hs_fell = 1; n_tests++;
        if (o0.h !== 16'd656) begin n_fail++; $display("FAIL hsync_fall got h=%0d exp 656", o0.h); end
      end
      if (!prev.hs && o0.hs) begin
        hs_rose = 1; n_tests++;
        if (o0.h !== 16'd752) begin n_fail++; $display("FAIL hsync_rise got h=%0d exp 752", o0.h); end
      end
      if (prev.br && !o0.br) begin
        br_fell = 1; n_tests++;
        if (o0.h !== 16'd640) begin n_fail++; $display("FAIL bright_fall got h=%0d exp 640", o0.h); end
      end
      if (prev.h == 16'd799 && o0.h != 16'd799) begin
        wrapped = 1; n_tests++;
        if (o0.h !== 16'd0 || o0.v !== 16'd1) begin
          n_fail++; $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=1", o0.h, o0.v);
        end
      end
      prev = o0;
    end
    n_tests++;
    if ({hs_fell, hs_rose, br_fell, wrapped} !== 4'b1111) begin
      n_fail++; $display("FAIL hline_events got=%b exp=1111", {hs_fell, hs_rose, br_fell, wrapped});
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    int   guard;
    // instance 0, mid-line at hCount=300
    pulse_reset(0);
    guard = 0;
    while (h0 != 16'd300 && guard < 2000) begin @(negedge clk); guard++; end
    n_tests++;
    if (h0 !== 16'd300) begin n_fail++; $display("FAIL reach_300 got h=%0d exp 300", h0); end
    #3 rstn[0] = 1'b0;
    #1;
    e = model(0, 0);
    n_tests++;
    if (o0 !== e) begin n_fail++; $display("FAIL async_rst_d0 got=%h exp=%h", o0, e); end
    repeat (2) @(negedge clk);
    rstn[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      sb.push_back(model(0, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o0 !== e) begin n_fail++; $display("FAIL restart_d0 k=%0d got=%h exp=%h", k, o0, e); end
    end
    // instance 1, mid-frame at (3,2)
    pulse_reset(1);
    guard = 0;
    while (!(h1 == 16'd3 && v1 == 16'd2) && guard < 200) begin @(negedge clk); guard++; end
    n_tests++;
    if (h1 !== 16'd3 || v1 !== 16'd2) begin
      n_fail++; $display("FAIL reach_3_2 got h=%0d v=%0d exp 3,2", h1, v1);
    end
    #3 rstn[1] = 1'b0;
    #1;
    e = model(1, 0);
    n_tests++;
    if (o1 !== e) begin n_fail++; $display("FAIL async_rst_d1 got=%h exp=%h", o1, e); end
    repeat (2) @(negedge clk);
    rstn[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      sb.push_back(model(1, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o1 !== e) begin n_fail++; $display("FAIL restart_d1 k=%0d got=%h exp=%h", k, o1, e); end
    end
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    int   last = -1, nfs = 0;
    pulse_reset(1);
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      sb.push_back(model(1, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o1 !== e) begin n_fail++; $display("FAIL frame_d1 k=%0d got=%h exp=%h", k, o1, e); end
      if (fs1) begin
        nfs++;
        if (last >= 0) begin
          n_tests++;
          if (k - last != 98) begin n_fail++; $display("FAIL fs_period_d1 got=%0d exp=98", k - last); end
        end
        last = k;
      end
    end
    n_tests++;
    if (nfs != 3) begin n_fail++; $display("FAIL fs_count_d1 got=%0d exp=3", nfs); end
  endtask

  task automatic test_clkdiv3();
    exp_t e;
    int   last = -1, nfs = 0;
    pulse_reset(2);
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      sb.push_back(model(2, k));
      @(negedge clk);
      e = sb.pop_front();
      n_tests++;
      if (o2 !== e) begin n_fail++; $display("FAIL frame_d2 k=%0d got=%h exp=%h", k, o2, e); end
      if (fs2) begin
        nfs++;
        if (last >= 0) begin
          n_tests++;
          if (k - last != 294) begin n_fail++; $display("FAIL fs_period_d2 got=%0d exp=294", k - last); end
        end
        last = k;
      end
    end
    n_tests++;
    if (nfs != 2) begin n_fail++; $display("FAIL fs_count_d2 got=%0d exp=2", nfs); end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_hline();
    test_midreset();
    test_frame_wrap();
    test_clkdiv3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
